// File: rtl/pmu_bitstream_tx.sv
// pmu_bitstream_tx: transmit end of the PMU serial configuration link.
// Serialises a 64-bit header, then for every block an optional 8-bit CRC key
// and 64 data bits, LSB-first on data_o, framed by en_o.
module pmu_bitstream_tx #(
  parameter int WORD_W = 64,
  parameter int CNT_W  = 32
) (
  input  logic              tck_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              checksum_en_i,
  input  logic [CNT_W-1:0]  block_count_i,
  input  logic [6:0]        last_bits_i,
  input  logic [WORD_W-1:0] word_i,
  input  logic              word_valid_i,
  output logic              word_ready_o,
  output logic              data_o,
  output logic              en_o,
  output logic              bit_valid_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    FETCH = 3'd2,
    PREP  = 3'd3,
    KEY   = 3'd4,
    DATA  = 3'd5,
    DONE  = 3'd6
  } state_t;

  state_t             r_state;
  logic [6:0]         r_bitCnt;
  logic [CNT_W-1:0]   r_remaining;
  logic [6:0]         r_lastBits;
  logic               r_crcEn;
  logic [WORD_W-1:0]  r_shift;
  logic [7:0]         r_lfsr;
  logic [7:0]         r_key;
  logic               r_data;
  logic               r_en;
  logic               r_bitValid;
  logic               r_done;
  logic               r_err;

  logic               w_startOk;
  logic [WORD_W-1:0]  w_header;
  logic [WORD_W-1:0]  w_keepMask;
  logic [WORD_W-1:0]  w_wordMasked;
  logic               w_prepBit;
  logic               w_p7;
  logic [7:0]         w_lfsrNext;

  assign word_ready_o = (r_state == FETCH);
  assign busy_o       = (r_state != IDLE);
  assign data_o       = r_data;
  assign en_o         = r_en;
  assign bit_valid_o  = r_bitValid;
  assign done_o       = r_done;
  assign err_o        = r_err;

  // Start-request legality, header image and the last-block bit mask
  always_comb begin
    w_startOk    = (block_count_i != '0) && (last_bits_i != 7'd0) && (last_bits_i <= 7'd64);
    w_header     = {25'b0, last_bits_i, block_count_i};
    w_keepMask   = ~({WORD_W{1'b1}} << last_bits_i);
    w_wordMasked = word_i;
    if (r_remaining == 1) begin
      w_wordMasked = word_i & w_keepMask;
    end
  end

  // Reverse LFSR step: walking the word from bit 63 down to 0 undoes the
  // receiver's forward LFSR, leaving the state the receiver must hold after the key
  always_comb begin
    w_prepBit     = r_shift[~r_bitCnt[5:0]];
    w_p7          = r_lfsr[0] ^ w_prepBit;
    w_lfsrNext[7] = w_p7;
    w_lfsrNext[6] = r_lfsr[7] ^ w_p7;
    w_lfsrNext[5] = r_lfsr[6] ^ w_p7;
    w_lfsrNext[4] = r_lfsr[5] ^ w_p7;
    w_lfsrNext[3] = r_lfsr[4];
    w_lfsrNext[2] = r_lfsr[3] ^ w_p7;
    w_lfsrNext[1] = r_lfsr[2];
    w_lfsrNext[0] = r_lfsr[1] ^ w_p7;
  end

  // Transfer sequencer; registered outputs describe the bit shown in the coming cycle
  always_ff @(posedge tck_i) begin
    if (!rst_i) begin
      r_state     <= IDLE;
      r_bitCnt    <= '0;
      r_remaining <= '0;
      r_lastBits  <= '0;
      r_crcEn     <= 1'b0;
      r_shift     <= '0;
      r_lfsr      <= '0;
      r_key       <= '0;
      r_data      <= 1'b0;
      r_en        <= 1'b0;
      r_bitValid  <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          r_data     <= 1'b0;
          r_bitValid <= 1'b0;
          r_en       <= 1'b0;
          if (start_i) begin
            if (w_startOk) begin
              r_state     <= HDR;
              r_remaining <= block_count_i;
              r_lastBits  <= last_bits_i;
              r_crcEn     <= checksum_en_i;
              r_data      <= w_header[0];
              r_shift     <= w_header >> 1;
              r_bitCnt    <= 7'd1;
              r_bitValid  <= 1'b1;
              r_en        <= 1'b1;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        HDR: begin
          if (r_bitCnt == 7'd64) begin
            r_state    <= FETCH;
            r_data     <= 1'b0;
            r_bitValid <= 1'b0;
          end else begin
            r_data   <= r_shift[0];
            r_shift  <= r_shift >> 1;
            r_bitCnt <= r_bitCnt + 7'd1;
          end
        end
        FETCH: begin
          if (word_valid_i) begin
            if (r_crcEn) begin
              r_state  <= PREP;
              r_shift  <= w_wordMasked;
              r_bitCnt <= 7'd0;
              r_lfsr   <= 8'h00;
            end else begin
              r_state    <= DATA;
              r_data     <= w_wordMasked[0];
              r_shift    <= w_wordMasked >> 1;
              r_bitCnt   <= 7'd1;
              r_bitValid <= 1'b1;
            end
          end
        end
        PREP: begin
          r_lfsr   <= w_lfsrNext;
          r_bitCnt <= r_bitCnt + 7'd1;
          if (r_bitCnt == 7'd63) begin
            r_state    <= KEY;
            r_data     <= w_lfsrNext[7];
            r_key      <= w_lfsrNext << 1;
            r_bitCnt   <= 7'd1;
            r_bitValid <= 1'b1;
          end
        end
        KEY: begin
          if (r_bitCnt == 7'd8) begin
            r_state  <= DATA;
            r_data   <= r_shift[0];
            r_shift  <= r_shift >> 1;
            r_bitCnt <= 7'd1;
          end else begin
            r_data   <= r_key[7];
            r_key    <= r_key << 1;
            r_bitCnt <= r_bitCnt + 7'd1;
          end
        end
        DATA: begin
          if (r_bitCnt == 7'd64) begin
            r_remaining <= r_remaining - 1'b1;
            r_data      <= 1'b0;
            r_bitValid  <= 1'b0;
            if (r_remaining == 1) begin
              r_state <= DONE;
              r_en    <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= FETCH;
            end
          end else begin
            r_data   <= r_shift[0];
            r_shift  <= r_shift >> 1;
            r_bitCnt <= r_bitCnt + 7'd1;
          end
        end
        DONE: begin
          r_state    <= IDLE;
          r_data     <= 1'b0;
          r_bitValid <= 1'b0;
          r_en       <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pmu_bitstream_tx.sv
// Self-checking bench for pmu_bitstream_tx: table of transfers with random
// words checked against a bit-queue model, plus reset/illegal-start sequences.
module tb_pmu_bitstream_tx;

  logic        tck_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b0;
  logic        checksum_en_i = 1'b0;
  logic [31:0] block_count_i = '0;
  logic [6:0]  last_bits_i = '0;
  logic [63:0] word_i = '0;
  logic        word_valid_i = 1'b0;
  logic        word_ready_o, data_o, en_o, bit_valid_o, busy_o, done_o, err_o;

  int checks = 0;
  int errors = 0;

  pmu_bitstream_tx dut (
    .tck_i(tck_i), .rst_i(rst_i), .start_i(start_i), .checksum_en_i(checksum_en_i),
    .block_count_i(block_count_i), .last_bits_i(last_bits_i), .word_i(word_i),
    .word_valid_i(word_valid_i), .word_ready_o(word_ready_o), .data_o(data_o),
    .en_o(en_o), .bit_valid_o(bit_valid_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 tck_i = ~tck_i;

  typedef struct {
    int unsigned n;
    int unsigned l;
    bit          crc;
    int          stall;
    bit          zeroWords;
    bit          poke;
    int          expValid;
  } vec_t;

  vec_t vecs[5];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Receiver forward LFSR: input enters bit 0, feedback from bit 7
  function automatic logic [7:0] rxStep(input logic [7:0] s, input logic b);
    logic [7:0] n;
    logic t;
    t = s[7];
    n[0] = b ^ t;
    n[1] = s[0] ^ t;
    n[2] = s[1];
    n[3] = s[2] ^ t;
    n[4] = s[3];
    n[5] = s[4] ^ t;
    n[6] = s[5] ^ t;
    n[7] = s[6] ^ t;
    return n;
  endfunction

  // The key is whichever 8-bit prefix drives the receiver back to zero after the word
  function automatic logic [7:0] findKey(input logic [63:0] w);
    logic [7:0] s;
    logic [7:0] k;
    for (int c = 0; c < 256; c++) begin
      k = c[7:0];
      s = 8'h00;
      for (int i = 0; i < 8; i++) s = rxStep(s, k[i]);
      for (int i = 0; i < 64; i++) s = rxStep(s, w[i]);
      if (s == 8'h00) return k;
    end
    return 8'h00;
  endfunction

  task automatic applyStimulus(input vec_t v, input string tag);
    logic [63:0] words[$];
    bit          got[$];
    bit          exp[$];
    logic [63:0] w;
    logic [63:0] hdr;
    logic [63:0] hdrGot;
    logic [7:0]  k;
    logic [7:0]  s;
    int          doneCnt, errCnt, cyc, fetchWait, mism, badBlk;
    bit          finished, enOk, stallOk;
    doneCnt = 0; errCnt = 0; cyc = 0; fetchWait = 0; mism = 0; badBlk = 0;
    finished = 0; enOk = 1; stallOk = 1;
    @(negedge tck_i);
    start_i = 1'b1;
    checksum_en_i = v.crc;
    block_count_i = v.n;
    last_bits_i = v.l[6:0];
    @(negedge tck_i);
    start_i = 1'b0;
    while (!finished && cyc < 4000) begin
      if (cyc == 0) checkOutput({tag, "_latency"}, {62'b0, bit_valid_o, en_o}, 64'h3);
      if (bit_valid_o) got.push_back(data_o);
      if (err_o) errCnt++;
      if (done_o) begin
        doneCnt++;
        finished = 1;
        if (en_o !== 1'b0) enOk = 0;
      end else if (en_o !== 1'b1) begin
        enOk = 0;
      end
      if (v.poke && cyc == 10) begin
        start_i = 1'b1;
        block_count_i = 32'd5;
        checksum_en_i = ~v.crc;
      end else begin
        start_i = 1'b0;
      end
      if (word_ready_o && !finished) begin
        if (words.size() == 0 && fetchWait < v.stall) begin
          fetchWait++;
          word_valid_i = 1'b0;
          if (bit_valid_o !== 1'b0 || en_o !== 1'b1) stallOk = 0;
        end else begin
          w = v.zeroWords ? 64'h0 : {$urandom, $urandom};
          word_i = w;
          word_valid_i = 1'b1;
          words.push_back(w);
        end
      end else begin
        word_valid_i = 1'b0;
      end
      cyc++;
      if (!finished) @(negedge tck_i);
    end
    checkOutput({tag, "_finished"}, {63'b0, finished}, 64'h1);
    @(negedge tck_i);
    checkOutput({tag, "_idle_after"}, {62'b0, busy_o, done_o}, 64'h0);
    checkOutput({tag, "_valid_bits"}, got.size(), v.expValid);
    checkOutput({tag, "_done_pulses"}, doneCnt, 1);
    checkOutput({tag, "_err_pulses"}, errCnt, 0);
    checkOutput({tag, "_en_framing"}, {63'b0, enOk}, 64'h1);
    checkOutput({tag, "_words"}, words.size(), v.n);
    if (v.stall > 0) begin
      checkOutput({tag, "_stall_cycles"}, fetchWait, v.stall);
      checkOutput({tag, "_stall_quiet"}, {63'b0, stallOk}, 64'h1);
    end
    hdr = {25'b0, v.l[6:0], v.n[31:0]};
    for (int i = 0; i < 64; i++) exp.push_back(hdr[i]);
    for (int b = 0; b < words.size(); b++) begin
      w = words[b];
      if (b == v.n - 1 && v.l < 64) w = w & ((64'h1 << v.l) - 64'h1);
      if (v.crc) begin
        k = findKey(w);
        for (int i = 0; i < 8; i++) exp.push_back(k[i]);
      end
      for (int i = 0; i < 64; i++) exp.push_back(w[i]);
    end
    for (int i = 0; i < exp.size() || i < got.size(); i++) begin
      if (i >= exp.size() || i >= got.size()) mism++;
      else if (exp[i] != got[i]) mism++;
    end
    checkOutput({tag, "_stream"}, mism, 0);
    if (v.zeroWords && got.size() >= 64) begin
      hdrGot = '0;
      for (int i = 0; i < 64; i++) hdrGot[i] = got[i];
      checkOutput({tag, "_header"}, hdrGot, 64'h00000040_00000001);
    end
    if (v.crc && got.size() == 64 + 72 * v.n) begin
      for (int b = 0; b < v.n; b++) begin
        s = 8'h00;
        for (int i = 0; i < 72; i++) s = rxStep(s, got[64 + 72 * b + i]);
        if (s != 8'h00) badBlk++;
      end
      checkOutput({tag, "_link_lfsr"}, badBlk, 0);
    end
  endtask

  task automatic startIllegal(input int unsigned n, input int unsigned l, input string tag);
    @(negedge tck_i);
    start_i = 1'b1;
    block_count_i = n;
    last_bits_i = l[6:0];
    @(negedge tck_i);
    start_i = 1'b0;
    checkOutput({tag, "_err"}, {62'b0, err_o, busy_o}, 64'h2);
    @(negedge tck_i);
    checkOutput({tag, "_err_clear"}, {62'b0, err_o, busy_o}, 64'h0);
  endtask

  task automatic resetMidData();
    int vcount, cyc;
    bit hit;
    vcount = 0; cyc = 0; hit = 0;
    @(negedge tck_i);
    start_i = 1'b1;
    checksum_en_i = 1'b0;
    block_count_i = 32'd2;
    last_bits_i = 7'd64;
    @(negedge tck_i);
    start_i = 1'b0;
    while (!hit && cyc < 500) begin
      if (bit_valid_o) vcount++;
      if (vcount >= 74) begin
        hit = 1;
        rst_i = 1'b0;
        word_valid_i = 1'b0;
      end else if (word_ready_o) begin
        word_i = {$urandom, $urandom};
        word_valid_i = 1'b1;
      end else begin
        word_valid_i = 1'b0;
      end
      cyc++;
      @(negedge tck_i);
    end
    checkOutput("rst_mid_reached", {63'b0, hit}, 64'h1);
    checkOutput("rst_mid_outputs",
                {57'b0, data_o, en_o, bit_valid_o, busy_o, done_o, err_o, word_ready_o}, 64'h0);
    rst_i = 1'b1;
  endtask

  initial begin
    vecs[0] = '{n: 1, l: 64, crc: 1, stall: 0,  zeroWords: 1, poke: 0, expValid: 136};
    vecs[1] = '{n: 2, l: 64, crc: 1, stall: 0,  zeroWords: 0, poke: 0, expValid: 208};
    vecs[2] = '{n: 3, l: 10, crc: 0, stall: 0,  zeroWords: 0, poke: 0, expValid: 256};
    vecs[3] = '{n: 2, l: 33, crc: 1, stall: 20, zeroWords: 0, poke: 0, expValid: 208};
    vecs[4] = '{n: 1, l: 1,  crc: 0, stall: 0,  zeroWords: 0, poke: 1, expValid: 128};

    rst_i = 1'b0;
    repeat (3) @(negedge tck_i);
    checkOutput("reset_outputs",
                {57'b0, data_o, en_o, bit_valid_o, busy_o, done_o, err_o, word_ready_o}, 64'h0);
    rst_i = 1'b1;

    for (int i = 0; i < 5; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

    startIllegal(0, 64, "illegal_n0");
    startIllegal(1, 65, "illegal_l65");
    startIllegal(3, 0, "illegal_l0");

    resetMidData();
    applyStimulus(vecs[0], "after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
